// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: single-transfer Wishbone classic master behind a valid/ready request port.
// Ports: req_* request in, rsp_* registered response pulse, cyc/stb/we/sel/adr/dat Wishbone out, dat_i/ack_i/err_i in.
module wb_master_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 15,
  parameter int SEL_W   = DATA_W / 8,
  parameter int TIMEOUT = 255,
  parameter int ALIGN   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              accept;
  logic              sel_zero;
  logic              tmo;
  logic              one_lane;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] rd_data;

  assign accept   = (state_q == IDLE) && req_valid_i;
  assign sel_zero = (req_sel_i == '0);
  assign tmo      = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; err and ack both end the cycle, err decides the status
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = sel_zero ? RESP : ACTIVE;
      ACTIVE:  if (err_i || ack_i || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs (all driven from flops)
  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b0;
    cyc_o       = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE:    req_ready_o = 1'b1;
      ACTIVE:  begin busy_o = 1'b1; cyc_o = 1'b1; end
      RESP:    begin busy_o = 1'b1; rsp_valid_o = 1'b1; end
      default: req_ready_o = 1'b0;
    endcase
  end

  assign stb_o      = cyc_o;
  assign we_o       = we_q;
  assign sel_o      = sel_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign rsp_err_o  = rsp_err_q;
  assign rsp_data_o = rsp_data_q;

  // lane masking; a lone selected byte is also copied to lane 0
  always_comb begin
    masked  = '0;
    aligned = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel_q[i]) begin
        masked[8*i +: 8] = dat_i[8*i +: 8];
        aligned[7:0]     = dat_i[8*i +: 8];
      end
    end
    one_lane = (sel_q != '0) &&
               ((sel_q & (sel_q - SEL_W'(1))) == '0);
    rd_data  = (ALIGN != 0 && one_lane) ? aligned : masked;
  end

  // response payload, loaded on the edge that enters RESP
  always_comb begin
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    if (accept && sel_zero) begin
      rsp_err_d = 1'b1;
    end else if (state_q == ACTIVE) begin
      if (err_i || (tmo && !ack_i)) rsp_err_d = 1'b1;
      else if (ack_i && !we_q)      rsp_data_d = rd_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // saturating timeout counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ACTIVE && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // bus-side request registers, held outside ACTIVE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q  <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (accept && !sel_zero) begin
      we_q  <= req_we_i;
      sel_q <= req_sel_i;
      adr_q <= req_addr_i;
      dat_q <= req_data_i;
    end
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: randomized scoreboard bench for wb_master_ctrl.
// Two instances (ALIGN=1 / ALIGN=0) share one request port and slave.
module tb_wb_master_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int SW  = 2;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [DW-1:0] dat_in = '0;
  logic          ack = 1'b0;
  logic          err = 1'b0;

  logic          a_ready, a_rv, a_rerr, a_busy, a_cyc, a_stb, a_we;
  logic [DW-1:0] a_rdata, a_dat;
  logic [SW-1:0] a_sel;
  logic [AW-1:0] a_adr;
  logic          b_ready, b_rv, b_rerr, b_busy, b_cyc, b_stb, b_we;
  logic [DW-1:0] b_rdata, b_dat;
  logic [SW-1:0] b_sel;
  logic [AW-1:0] b_adr;

  always #5 clk = ~clk;

  wb_master_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO), .ALIGN(1)) u_a (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(a_ready),
    .req_we_i(req_we), .req_sel_i(req_sel),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(a_rv), .rsp_err_o(a_rerr), .rsp_data_o(a_rdata),
    .busy_o(a_busy), .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we),
    .sel_o(a_sel), .adr_o(a_adr), .dat_o(a_dat),
    .dat_i(dat_in), .ack_i(ack), .err_i(err)
  );

  wb_master_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO), .ALIGN(0)) u_b (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(b_ready),
    .req_we_i(req_we), .req_sel_i(req_sel),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(b_rv), .rsp_err_o(b_rerr), .rsp_data_o(b_rdata),
    .busy_o(b_busy), .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we),
    .sel_o(b_sel), .adr_o(b_adr), .dat_o(b_dat),
    .dat_i(dat_in), .ack_i(ack), .err_i(err)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t qa[$];
  rsp_t qb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // read data as seen by the CPU: selected bytes, or lone byte in lane 0
  function automatic logic [DW-1:0] ref_read(input logic [SW-1:0] sel,
                                             input logic [DW-1:0] d,
                                             input bit align);
    logic [DW-1:0] m;
    int lane;
    m = '0;
    lane = 0;
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) begin
        m = m | (DW'(8'hFF) << (8 * i));
        lane = i;
      end
    end
    if (align && $countones(sel) == 1)
      return (d >> (8 * lane)) & DW'(8'hFF);
    return d & m;
  endfunction

  // monitor: pop and compare on every response pulse
  always @(negedge clk) begin : mon
    rsp_t e;
    if (a_rv) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_rsp_err", a_rerr, e.err);
        chk("a_rsp_data", a_rdata, e.data);
      end
    end
    if (b_rv) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_rsp_err", b_rerr, e.err);
        chk("b_rsp_data", b_rdata, e.data);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, {a_ready, b_ready}, 2'b11);
    chk({tag, "_rv"}, {a_rv, b_rv}, 2'b00);
    chk({tag, "_rerr"}, {a_rerr, b_rerr}, 2'b00);
    chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
    chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
    chk({tag, "_cyc"}, {a_cyc, a_stb, b_cyc, b_stb}, 4'b0000);
    chk({tag, "_we"}, {a_we, b_we}, 2'b00);
    chk({tag, "_sel"}, {a_sel, b_sel}, 0);
    chk({tag, "_adr"}, {a_adr, b_adr}, 0);
    chk({tag, "_dat"}, {a_dat, b_dat}, 0);
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave (timeout)
  task automatic do_req(input logic we, input logic [SW-1:0] sel,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW-1:0] rdat, input int waits,
                        input int mode);
    int   w;
    int   ncyc;
    int   exp_cyc;
    bit   iserr;
    rsp_t ea, eb;
    w = 0;
    ncyc = 0;
    @(negedge clk);
    while (!a_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_latency", w, 0);
    if (sel == '0) begin
      exp_cyc = 0; iserr = 1'b1;
    end else if (mode == 3) begin
      exp_cyc = TMO; iserr = 1'b1;
    end else begin
      exp_cyc = waits + 1; iserr = (mode != 0);
    end
    ea.err  = iserr;
    ea.data = (iserr || we) ? '0 : ref_read(sel, rdat, 1'b1);
    eb.err  = iserr;
    eb.data = (iserr || we) ? '0 : ref_read(sel, rdat, 1'b0);
    qa.push_back(ea);
    qb.push_back(eb);
    req_valid = 1'b1;
    req_we    = we;
    req_sel   = sel;
    req_addr  = addr;
    req_data  = data;
    dat_in    = rdat;
    ack       = 1'($urandom);
    err       = 1'($urandom);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_sel   = SW'($urandom);
    req_addr  = AW'($urandom);
    req_data  = DW'($urandom);
    ack       = 1'b0;
    err       = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!a_cyc) break;
      ncyc++;
      chk("stb", {a_stb, b_cyc, b_stb}, 3'b111);
      chk("ready_low", a_ready, 0);
      chk("adr", a_adr, addr);
      chk("dat", a_dat, data);
      chk("we", a_we, we);
      chk("sel", a_sel, sel);
      ack = (mode == 0 || mode == 2) && k == waits;
      err = (mode == 1 || mode == 2) && k == waits;
    end
    chk("cyc_count", ncyc, exp_cyc);
    chk("rsp_pulse", {a_rv, b_rv, b_cyc}, 3'b110);
    // junk on the slave lines during RESP must be ignored
    ack = 1'($urandom);
    err = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2'b11, 15'h1234, 16'hBEEF, 16'h0000, 0, 0);
    do_req(1'b0, 2'b10, 15'h0010, 16'h0000, 16'hA55A, 2, 0);
    do_req(1'b0, 2'b01, 15'h0011, 16'h0000, 16'hA55A, 1, 0);
    do_req(1'b0, 2'b11, 15'h0012, 16'h0000, 16'hA55A, 0, 0);
    do_req(1'b0, 2'b11, 15'h0020, 16'h0000, 16'h1357, 0, 3);
    do_req(1'b0, 2'b11, 15'h0021, 16'h0000, 16'h2468, 0, 0);
    do_req(1'b0, 2'b11, 15'h0030, 16'h0000, 16'h7777, 1, 2);
    do_req(1'b0, 2'b01, 15'h0031, 16'h0000, 16'h7777, 0, 1);
    do_req(1'b1, 2'b00, 15'h0040, 16'h1111, 16'h0000, 0, 0);

    // reset while a write is waiting on the slave
    @(negedge clk);
    ack = 1'b0;
    err = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_sel   = 2'b11;
    req_addr  = 15'h0100;
    req_data  = 16'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cyc", a_cyc, 1);
    @(negedge clk);
    chk("pre_rst_cyc2", a_cyc, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    check_reset("held_rst");
    rst_n = 1'b1;
    do_req(1'b1, 2'b11, 15'h0002, 16'h0F0F, 16'h0000, 0, 0);

    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom), SW'($urandom), AW'($urandom), DW'($urandom),
             DW'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_master_ctrl.md
# wb_master_ctrl

Parametrised Wishbone classic-cycle bus master that replaces the fixed 16-bit memory controller. It sits between the CPU datapath/control FSM and the system bus. It accepts one request at a time over a valid/ready handshake and registers the address, data and lane selects at acceptance. It runs a single Wishbone transfer, terminating on ack, bus error or timeout, and returns one registered response pulse with lane-masked and optionally aligned read data.

## Interface
- DATA_W, 16: bus data width; multiple of 8, 8..64.
- ADDR_W, 15: bus address width.
- SEL_W, DATA_W/8: byte-lane count; derived, not overridden.
- TIMEOUT, 255: maximum ACTIVE cycles without ack_i/err_i; 0 disables the timeout.
- ALIGN, 1: if 1, a single-lane read is shifted down to lane 0.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request offered.
- req_ready_o  out  1  master can accept a request (high only in IDLE).
- req_we_i  in  1  1 = write, 0 = read.
- req_sel_i  in  SEL_W  byte-lane enables.
- req_addr_i  in  ADDR_W  transfer address.
- req_data_i  in  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_err_o  out  1  response is an error (bus error, timeout, or sel = 0); valid with rsp_valid_o.
- rsp_data_o  out  DATA_W  read data; 0 for writes and errors.
- busy_o  out  1  high in ACTIVE and RESP.
- cyc_o, stb_o  out  1  Wishbone cycle and strobe; identical.
- we_o  out  1  Wishbone write enable.
- sel_o  out  SEL_W  Wishbone byte selects.
- adr_o  out  ADDR_W  Wishbone address.
- dat_o  out  DATA_W  Wishbone write data.
- dat_i  in  DATA_W  Wishbone read data.
- ack_i  in  1  slave acknowledge.
- err_i  in  1  slave error.

## Operation
- **States:** IDLE, ACTIVE, RESP.
- **IDLE to ACTIVE:** on req_valid_i & req_ready_o with req_sel_i ≠ 0. At that edge the master latches we/sel/addr/data into the registers that drive we_o/sel_o/adr_o/dat_o and clears the timeout counter.
- **IDLE to RESP (sel = 0):** if the request is accepted with req_sel_i = 0, no bus cycle runs. The master goes to RESP with rsp_err_o = 1.
- **ACTIVE:** cyc_o = stb_o = 1. Bus outputs are held stable. The timeout counter increments every cycle.
- **ACTIVE to RESP:** on the first of:
  - err_i = 1: error response.
  - ack_i = 1: normal response.
  - counter = TIMEOUT-1 with TIMEOUT ≠ 0: error response.
  - ack_i and err_i both high in the same cycle: err_i wins.
- **RESP:** rsp_valid_o = 1 for exactly one cycle, then IDLE. cyc_o = stb_o = 0.
- **Read data capture:** on the ack edge, rsp_data_o captures dat_i with unselected lanes forced to 0. If ALIGN = 1 and exactly one sel bit is set, that byte goes to lane 0 and the upper lanes are 0.
- **Writes:** rsp_data_o = 0.
- **Bus outputs outside ACTIVE:** we_o, sel_o, adr_o and dat_o keep their last latched value; only cyc_o/stb_o qualify them.
- **Reset:** asserting rst_i (low) at any time forces IDLE immediately and asynchronously, dropping cyc_o/stb_o mid-transfer. Outputs after reset:
  - req_ready_o = 1
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_data_o = 0
  - busy_o = 0, cyc_o = 0, stb_o = 0, we_o = 0
  - sel_o = 0, adr_o = 0, dat_o = 0
- **Timeout counter:** width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- **Accept:** the request is sampled at edge N. cyc_o rises after edge N (visible in cycle N+1).
- **Zero-wait slave:** ack_i high in cycle N+1. The transfer ends at edge N+1; rsp_valid_o is high in cycle N+2. req_ready_o is high again in cycle N+3.
- **Throughput:** minimum 3 cycles per transfer. Back-to-back requests are accepted on every third edge with a zero-wait slave.
- **Wait states:** each cycle of wait state adds one cycle of latency.
- **Timeout:** with no ack, cyc_o is high for exactly TIMEOUT cycles, then rsp_valid_o = 1 and rsp_err_o = 1.
- **Bus signal timing:** ack_i/err_i are sampled only in ACTIVE. ack_i/err_i pulses in IDLE or RESP are ignored.
- **Request-side timing:** req_* inputs are ignored whenever req_ready_o = 0. All outputs are registered; there is no combinational path from ack_i/err_i to outputs.

## Test plan
All scenarios use DATA_W = 16 and TIMEOUT = 4.

1. **Word write, zero-wait slave.** Request we = 1, sel = 11, addr = 0x1234, data = 0xBEEF, acked in the first ACTIVE cycle. Required: cyc_o high for 1 cycle with adr_o = 0x1234, dat_o = 0xBEEF, we_o = 1; rsp_valid_o = 1 two cycles after accept; rsp_err_o = 0; rsp_data_o = 0.
2. **High-byte read, ALIGN = 1.** Request we = 0, sel = 10, dat_i = 0xA55A, acked after 2 wait states. Required: cyc_o high for 3 cycles; rsp_data_o = 0x00A5. With ALIGN = 0: rsp_data_o = 0xA500. Low-byte read (sel = 01) returns 0x005A in both modes.
3. **Timeout.** Read with no ack. Required: cyc_o high for exactly 4 cycles; rsp_valid_o = 1, rsp_err_o = 1, rsp_data_o = 0; the next request is accepted normally.
4. **Simultaneous ack and err.** ack_i and err_i high in the same ACTIVE cycle. Required: rsp_err_o = 1. A separate err_i-only case also returns rsp_err_o = 1.
5. **Zero lane select.** Request with sel = 00. Required: no cyc_o pulse; rsp_valid_o = 1 with rsp_err_o = 1 in the cycle after accept.
6. **Reset mid-transfer.** Drive rst_i low while cyc_o = 1 during a wait-stated write. Required: cyc_o/stb_o fall asynchronously with no clock edge; all outputs take their reset values; after release, a new request of 0x0F0F to addr 0x0002 completes normally.
